// File: rtl/nv_nvdla_attn_mcif_mem_model.sv
// MCIF-side memory responder: in-order outstanding read bursts, fixed-latency pipelined writes.
// Define NVDLA_ATTN_MEM_STALL_EN to add LFSR-driven request back-pressure and response bubbles.
module nv_nvdla_attn_mcif_mem_model #(
  parameter int unsigned DATA_W     = 512,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned RD_LAT     = 3,
  parameter int unsigned WR_LAT     = 5,
  parameter int unsigned MAX_OUTS   = 4,
  parameter int unsigned BURST_W    = 4
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rst,
  input  logic                        attn2mcif_rd_req_valid,
  output logic                        attn2mcif_rd_req_ready,
  input  logic [ADDR_W+BURST_W-1:0]   attn2mcif_rd_req_pd,
  output logic                        mcif2attn_rd_rsp_valid,
  input  logic                        mcif2attn_rd_rsp_ready,
  output logic [DATA_W:0]             mcif2attn_rd_rsp_pd,
  input  logic                        attn2mcif_wr_req_valid,
  output logic                        attn2mcif_wr_req_ready,
  input  logic [ADDR_W+DATA_W-1:0]    attn2mcif_wr_req_pd,
  output logic                        mcif2attn_wr_rsp_complete,
  output logic [$clog2(MAX_OUTS):0]   rd_outs_cnt
);

  localparam int unsigned OFF   = $clog2(DATA_W / 8);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = $clog2(MAX_OUTS) + 1;
  localparam int unsigned PTR_W = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
  localparam int unsigned LAT_W = $clog2(RD_LAT + 1);

  typedef enum logic {ST_IDLE, ST_STREAM} state_e;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx_q [MAX_OUTS];
  logic [BURST_W-1:0]    len_q [MAX_OUTS];
  logic [LAT_W-1:0]      lat_q [MAX_OUTS];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q, nxt_ptr;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rd_rdy_q;
  state_e                state_q, state_d;
  logic [BURST_W-1:0]    beat_q, beat_d;
  logic [WR_LAT-1:0]     wr_pipe_q;
  logic                  cpl_q;
  logic                  rd_acc, wr_acc, rd_fire, rsp_last, pop;
  logic                  rsp_vld, rd_gate, wr_gate;
  logic [DEPTH_LOG2-1:0] rsp_idx, rd_req_idx, wr_req_idx;
  logic                  unused_pd_bits;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

`ifdef NVDLA_ATTN_MEM_STALL_EN
  logic [15:0] lfsr_q;
  logic        pres_q;

  // pres_q marks a beat shown but not yet taken; it must not be withdrawn.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      lfsr_q <= 16'hACE1;
      pres_q <= 1'b0;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      pres_q <= rsp_vld & ~mcif2attn_rd_rsp_ready;
    end
  end

  assign rd_gate = lfsr_q[0];
  assign wr_gate = lfsr_q[1];
  assign rsp_vld = (state_q == ST_STREAM) & (pres_q | lfsr_q[2]);
`else
  assign rd_gate = 1'b1;
  assign wr_gate = 1'b1;
  assign rsp_vld = (state_q == ST_STREAM);
`endif

  assign attn2mcif_rd_req_ready    = rd_rdy_q & rd_gate;
  assign attn2mcif_wr_req_ready    = wr_gate;
  assign rd_acc     = attn2mcif_rd_req_valid & attn2mcif_rd_req_ready;
  assign wr_acc     = attn2mcif_wr_req_valid & attn2mcif_wr_req_ready;
  assign rd_req_idx = attn2mcif_rd_req_pd[BURST_W+OFF +: DEPTH_LOG2];
  assign wr_req_idx = attn2mcif_wr_req_pd[DATA_W+OFF +: DEPTH_LOG2];
  assign nxt_ptr    = ptr_inc(rd_ptr_q);
  assign rsp_idx    = idx_q[rd_ptr_q] + DEPTH_LOG2'(beat_q);
  assign rsp_last   = (beat_q == len_q[rd_ptr_q]);
  assign rd_fire    = rsp_vld & mcif2attn_rd_rsp_ready;
  assign pop        = rd_fire & rsp_last;
  assign unused_pd_bits = ^{attn2mcif_rd_req_pd, attn2mcif_wr_req_pd};

  assign mcif2attn_rd_rsp_valid    = rsp_vld;
  assign mcif2attn_rd_rsp_pd       = rsp_vld ? {rsp_last, mem[rsp_idx]} : '0;
  assign mcif2attn_wr_rsp_complete = cpl_q;
  assign rd_outs_cnt               = cnt_q;

  // Response FSM; chains straight into the next burst when its latency has already elapsed.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q + CNT_W'(rd_acc) - CNT_W'(pop);
    case (state_q)
      ST_IDLE: begin
        if ((cnt_q != '0) && (lat_q[rd_ptr_q] == '0)) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (rd_fire) begin
          if (rsp_last) begin
            beat_d  = '0;
            state_d = ((cnt_q > CNT_W'(1)) && (lat_q[nxt_ptr] == '0)) ? ST_STREAM : ST_IDLE;
          end else begin
            beat_d = beat_q + BURST_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rd_rdy_q  <= 1'b1;
      wr_pipe_q <= '0;
      cpl_q     <= 1'b0;
      for (int i = 0; i < int'(MAX_OUTS); i++) begin
        idx_q[i] <= '0;
        len_q[i] <= '0;
        lat_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      cnt_q     <= cnt_d;
      rd_rdy_q  <= (cnt_d < CNT_W'(MAX_OUTS));
      wr_pipe_q <= (wr_pipe_q << 1) | WR_LAT'(wr_acc);
      cpl_q     <= wr_pipe_q[WR_LAT-1];
      if (pop) rd_ptr_q <= nxt_ptr;
      for (int i = 0; i < int'(MAX_OUTS); i++) begin
        if (lat_q[i] != '0) lat_q[i] <= lat_q[i] - LAT_W'(1);
      end
      if (rd_acc) begin
        idx_q[wr_ptr_q] <= rd_req_idx;
        len_q[wr_ptr_q] <= attn2mcif_rd_req_pd[BURST_W-1:0];
        lat_q[wr_ptr_q] <= LAT_W'(RD_LAT - 1);
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
    end
  end

  // Array deliberately has no reset so contents survive a core reset.
  always_ff @(posedge nvdla_core_clk) begin
    if (wr_acc) mem[wr_req_idx] <= attn2mcif_wr_req_pd[DATA_W-1:0];
  end

endmodule

// File: doc/nv_nvdla_attn_mcif_mem_model.md
Name: nv_nvdla_attn_mcif_mem_model

Overview:
- Parametrised, synthesizable MCIF-side memory responder for the attention partition's DMA read and write paths.
- Successor to the single-outstanding, fixed-latency behavioural memory model. Adds:
  - up to MAX_OUTS in-order outstanding reads;
  - multi-beat read bursts;
  - configurable read and write latencies;
  - pipelined write completions.
- Sits between the attention partition's mcif ports and the sim/FPGA top in place of the real MCIF.

Parameters:
DATA_W, 512, data beat width in bits (power of two, >=64)
ADDR_W, 32, byte address width
DEPTH_LOG2, 10, log2 of memory depth in beats
RD_LAT, 3, cycles from read accept to first rsp_valid (>=1)
WR_LAT, 5, cycles from write accept to complete pulse (>=1)
MAX_OUTS, 4, max outstanding read requests (power of two, >=1)
BURST_W, 4, width of burst-length field (beats = len+1)

Ports:
nvdla_core_clk  in  1  core clock
nvdla_core_rst  in  1  asynchronous active-high reset
attn2mcif_rd_req_valid  in  1  read request valid
attn2mcif_rd_req_ready  out  1  read request ready
attn2mcif_rd_req_pd  in  ADDR_W+BURST_W  {addr[ADDR_W-1:0], len[BURST_W-1:0]}
mcif2attn_rd_rsp_valid  out  1  read beat valid
mcif2attn_rd_rsp_ready  in  1  read beat ready
mcif2attn_rd_rsp_pd  out  DATA_W+1  {last, data[DATA_W-1:0]}
attn2mcif_wr_req_valid  in  1  write request valid
attn2mcif_wr_req_ready  out  1  write request ready
attn2mcif_wr_req_pd  in  ADDR_W+DATA_W  {addr, data}
mcif2attn_wr_rsp_complete  out  1  one-cycle write completion pulse
rd_outs_cnt  out  $clog2(MAX_OUTS)+1  current outstanding reads (status)

Behaviour:
- Single clock; nvdla_core_rst is asynchronous and active-high.
- Reset values:
  - rd_req_ready=1, wr_req_ready=1;
  - rd_rsp_valid=0, rd_rsp_pd=0;
  - wr_rsp_complete=0, rd_outs_cnt=0.
  - Queue pointers and write pipe are cleared. Memory array is NOT reset; contents persist.
- Addressing:
  - Beat index = addr[OFF +: DEPTH_LOG2], where OFF = log2(DATA_W/8).
  - Low OFF bits are ignored.
  - Index arithmetic is modulo 2^DEPTH_LOG2, so bursts wrap from the top of memory to index 0.
- Read queue:
  - Circular FIFO of MAX_OUTS entries, each holding {index, len, lat_cnt}.
  - Accept on valid&ready: push with lat_cnt=RD_LAT-1.
  - Every entry with lat_cnt>0 decrements each cycle, saturating at 0.
  - rd_req_ready = (count < MAX_OUTS). Registered; a pop in the same cycle does not free a slot until the next cycle.
- Read response states:
  - IDLE: move to STREAM when the queue is non-empty and head lat_cnt==0.
  - STREAM: rsp_valid=1; data = mem[head.index+beat]; last = (beat==head.len).
    - On valid&ready: beat++.
    - If last: pop head, beat=0, then go to STREAM if the next head is ready, else IDLE.
    - rsp_valid and pd must hold stable while ready is low.
- Read latency: request accepted at edge T gives first rsp_valid at edge T+RD_LAT, provided it is at the queue head.
  - Later requests are served back-to-back with no bubble if already aged.
  - Responses are strictly in request order.
- Write path:
  - wr_req_ready is always 1.
  - Accept at edge T writes mem[index]=data at T.
  - A WR_LAT-deep shift register of accept flags produces complete=1 for one cycle at T+WR_LAT.
  - N back-to-back writes give N back-to-back pulses.
- Read-after-write: data is sampled combinationally from the array when a beat is presented. A write accepted at edge T is visible to any beat presented at T+1 or later.
- Simultaneous push and pop: both are applied; count is unchanged.
- Reset mid-operation:
  - The in-flight burst is abandoned; no further beats are issued.
  - Pending completions are dropped.
  - Writes already accepted remain in memory.

Optional Feature:
NVDLA_ATTN_MEM_STALL_EN
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) advances every cycle.
  - rd_req_ready and wr_req_ready are each additionally ANDed with lfsr[0] and lfsr[1] respectively.
  - STREAM inserts a bubble (rsp_valid=0) on any cycle where lfsr[2]==0 and no beat is currently presented-but-unaccepted.
  - A beat that has been presented is never withdrawn.
- Undefined: readiness depends on capacity only; STREAM has no bubbles.

Test Plan:
- Preload mem[0x10]=A. Read addr 0x400, len=0, accepted at cycle 0 -> rsp_valid at cycle 3 with data A and last=1; rd_outs_cnt goes 1 then 0.
- 5 reads issued back-to-back with rsp_ready=1, MAX_OUTS=4 -> 5th request sees ready=0 until the first pop. Responses return in order; first response at +3; no bubbles between beats.
- Burst addr 0xFFC0 (index 1023), len=2 -> beats from index 1023, 0, 1; last asserted only on the 3rd beat.
- rsp_ready held low for 4 cycles mid-burst -> pd stable and valid held; beat count correct after release.
- 3 back-to-back writes at cycles 0, 1, 2 -> complete pulses at cycles 5, 6, 7. A read of the first write's address accepted at cycle 1 returns the written data.
- Assert reset while a burst is streaming and 2 writes are pending -> rsp_valid=0 and complete=0 immediately. After reset, a read returns the previously written data.
